jedro_1_lsu: RTL and testbench

Load-store unit of the jedro_1 core, directly downstream of the decoder's `lsu_new_ctrl_o` / `lsu_ctrl_o` / `lsu_regdest_o` outputs.
- Accepts one memory operation at a time.
- Drives the word-addressed, byte-enabled data RAM port.
- Aligns, sign-extends or zero-extends load data and writes it back to the register file.
- Detects misaligned and illegal memory operations before any RAM access.

---
 rtl/jedro_1_lsu.sv | 78 +++++++
 tb/tb_jedro_1_lsu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu: single-issue load-store unit with lane alignment, load extension and misaligned/illegal rejection
module jedro_1_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      new_ctrl_i,
  input  logic [3:0]                ctrl_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      ready_o,
  output logic                      ram_en_o,
  output logic [3:0]                ram_we_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [31:0]               ram_wdata_o,
  input  logic [31:0]               ram_rdata_i,
  output logic                      rf_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_dest_o,
  output logic [31:0]               rf_data_o,
  output logic                      misaligned_o,
  output logic                      illegal_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, RDATA, WB, ERR} state_t;
  state_t state, state_nxt;
  logic [3:0] ctrl_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] wdata_q, data_q, lane, ld_data;
  logic [1:0] a;
  logic ill, mis, ill_q;
  assign a = addr_q[1:0];
  assign ill = ctrl_i[3] ? ctrl_i[2:0] > 3'd2 : (ctrl_i[1:0] == 2'd3 || ctrl_i[2:1] == 2'b11);
  assign mis = (ctrl_i[1:0] == 2'd1 && addr_i[0]) || (ctrl_i[1:0] == 2'd2 && addr_i[1:0] != 2'd0);
  assign lane = ram_rdata_i >> {a, 3'b000};
  assign ld_data = ctrl_q[1:0] == 2'd0 ? {{24{~ctrl_q[2] & lane[7]}}, lane[7:0]} :
                   ctrl_q[1:0] == 2'd1 ? {{16{~ctrl_q[2] & lane[15]}}, lane[15:0]} : ram_rdata_i;
  always_comb begin
    state_nxt = state == IDLE  ? (new_ctrl_i ? ((ill || mis) ? ERR : ISSUE) : IDLE) :
                state == ISSUE ? (ctrl_q[3] ? IDLE : RDATA) :
                state == RDATA ? WB : IDLE;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      ctrl_q  <= '0;
      dest_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && new_ctrl_i) begin
        ctrl_q  <= ctrl_i;
        dest_q  <= regdest_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        ill_q   <= ill;
      end
      if (state == RDATA) data_q <= ld_data;
    end
  end
  assign ready_o = state == IDLE;
  assign ram_en_o = state == ISSUE;
  assign ram_we_o = !(ram_en_o && ctrl_q[3]) ? 4'b0000 :
                    ctrl_q[1:0] == 2'd0 ? 4'b0001 << a :
                    ctrl_q[1:0] == 2'd1 ? 4'b0011 << a : 4'b1111;
  assign ram_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign ram_wdata_o = ctrl_q[1:0] == 2'd0 ? {4{wdata_q[7:0]}} :
                       ctrl_q[1:0] == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  assign rf_wb_o = state == WB && dest_q != '0;
  assign rf_dest_o = dest_q;
  assign rf_data_o = data_q;
  assign misaligned_o = state == ERR && !ill_q;
  assign illegal_o = state == ERR && ill_q;
endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu: randomized and directed checks of jedro_1_lsu against a transaction-level model
module tb_jedro_1_lsu;
  localparam int NC = 4096;
  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wb;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        mis;
    logic        ill;
  } ev_t;
  logic clk_i = 1'b0, rstn_i = 1'b0, new_ctrl_i = 1'b0;
  logic [3:0] ctrl_i = '0;
  logic [4:0] regdest_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, ram_rdata_i = '0;
  logic ready_o, ram_en_o, rf_wb_o, misaligned_o, illegal_o;
  logic [3:0] ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o, rf_data_o;
  logic [4:0] rf_dest_o;
  int cyc = 0, n_chk = 0, n_fail = 0, free = 0, t1 = 0, t2 = 0;
  logic [31:0] mem [0:15];
  logic [31:0] mdl [0:15];
  ev_t ex [0:NC-1];

  jedro_1_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .new_ctrl_i(new_ctrl_i), .ctrl_i(ctrl_i),
    .regdest_i(regdest_i), .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .rf_wb_o(rf_wb_o),
    .rf_dest_o(rf_dest_o), .rf_data_o(rf_data_o), .misaligned_o(misaligned_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return i == 0 ? 32'h80FF7F01 : 32'h9E3779B9 * i;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Data RAM: requests are sampled mid-cycle and served on the following rising edge.
  initial begin
    logic en;
    logic [3:0] we;
    logic [3:0] wi;
    logic [31:0] wd;
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk_i);
      en = ram_en_o; we = ram_we_o; wi = ram_addr_o[5:2]; wd = ram_wdata_o;
      @(posedge clk_i);
      if (en) begin
        ram_rdata_i <= mem[wi];
        for (int i = 0; i < 4; i++) if (we[i]) mem[wi][8*i+:8] = wd[8*i+:8];
      end
    end
  end

  // Model of one accepted operation decided at monitor slot c; the accepting edge follows.
  task automatic accept(input int c);
    logic [2:0] f;
    logic st, il, ms;
    int sz, ln, w;
    longint v;
    f = ctrl_i[2:0]; st = ctrl_i[3];
    sz = 1 << f[1:0]; ln = int'(addr_i[1:0]); w = int'(addr_i[5:2]);
    il = st ? (f > 3'd2) : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ms = (addr_i % sz) != 0;
    if (il) begin ex[c+1].ill = 1'b1; free = c + 2; end
    else if (ms) begin ex[c+1].mis = 1'b1; free = c + 2; end
    else if (st) begin
      ex[c+1].en = 1'b1;
      ex[c+1].addr = {addr_i[31:2], 2'b00};
      for (int l = 0; l < 4; l++) ex[c+1].wdata[8*l+:8] = wdata_i[8*(l % sz)+:8];
      for (int i = 0; i < sz; i++) begin
        ex[c+1].we[ln+i] = 1'b1;
        mdl[w][8*(ln+i)+:8] = wdata_i[8*i+:8];
      end
      free = c + 2;
    end else begin
      v = 0;
      ex[c+1].en = 1'b1;
      ex[c+1].addr = {addr_i[31:2], 2'b00};
      for (int i = 0; i < sz; i++) v = v | (longint'(mdl[w][8*(ln+i)+:8]) << (8*i));
      if (!f[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
      ex[c+3].wb = regdest_i != 5'd0;
      ex[c+3].dest = regdest_i;
      ex[c+3].data = v[31:0];
      free = c + 4;
    end
  endtask

  // Compare process: every mid-cycle slot is checked against the model.
  initial begin
    ev_t e;
    int c;
    for (int i = 0; i < 16; i++) mdl[i] = init_word(i);
    for (int k = 0; k < NC; k++) ex[k] = '0;
    forever begin
      @(negedge clk_i);
      c = cyc;
      if (!rstn_i) begin
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_en", 32'(ram_en_o), 0);
        chk("rst_we", 32'(ram_we_o), 0);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_wdata", ram_wdata_o, 0);
        chk("rst_wb", 32'(rf_wb_o), 0);
        chk("rst_dest", 32'(rf_dest_o), 0);
        chk("rst_data", rf_data_o, 0);
        chk("rst_mis", 32'(misaligned_o), 0);
        chk("rst_ill", 32'(illegal_o), 0);
        for (int k = c; k < NC; k++) ex[k] = '0;
        free = 0;
      end else begin
        e = ex[c];
        chk("ready", 32'(ready_o), 32'(c >= free));
        chk("ram_en", 32'(ram_en_o), 32'(e.en));
        chk("ram_we", 32'(ram_we_o), 32'(e.we));
        chk("rf_wb", 32'(rf_wb_o), 32'(e.wb));
        chk("misaligned", 32'(misaligned_o), 32'(e.mis));
        chk("illegal", 32'(illegal_o), 32'(e.ill));
        if (e.en) chk("ram_addr", ram_addr_o, e.addr);
        if (e.en && e.we != 4'b0) chk("ram_wdata", ram_wdata_o, e.wdata);
        if (e.wb) begin
          chk("rf_dest", 32'(rf_dest_o), 32'(e.dest));
          chk("rf_data", rf_data_o, e.data);
        end
        if (c >= free && new_ctrl_i && c + 3 < NC) accept(c);
      end
    end
  end

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Presents an operation and returns 1 time unit after the edge that accepted it.
  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                    input logic [4:0] d, output int t);
    int n;
    n = 0;
    new_ctrl_i = 1'b1; ctrl_i = c; addr_i = a; wdata_i = w; regdest_i = d;
    @(negedge clk_i);
    while (!ready_o && n < 20) begin n++; @(negedge clk_i); end
    chk("accept_bound", 32'(ready_o), 1);
    @(posedge clk_i);
    #1;
    t = cyc;
    new_ctrl_i = 1'b0;
  endtask

  task automatic load_lit(input string n, input logic [3:0] c, input logic [31:0] a,
                          input logic [4:0] d, input logic [31:0] v);
    op(c, a, 32'h0, d, t1);
    @(negedge clk_i);
    chk({n, "_en"}, 32'(ram_en_o), 1);
    @(negedge clk_i);
    chk({n, "_wb_early"}, 32'(rf_wb_o), 0);
    @(negedge clk_i);
    chk({n, "_wb"}, 32'(rf_wb_o), 32'(d != 5'd0));
    if (d != 5'd0) begin
      chk({n, "_data"}, rf_data_o, v);
      chk({n, "_dest"}, 32'(rf_dest_o), 32'(d));
    end
    sync();
  endtask

  task automatic err_lit(input string n, input logic [3:0] c, input logic [31:0] a,
                         input logic m, input logic i);
    op(c, a, 32'h12345678, 5'd1, t1);
    @(negedge clk_i);
    chk({n, "_mis"}, 32'(misaligned_o), 32'(m));
    chk({n, "_ill"}, 32'(illegal_o), 32'(i));
    chk({n, "_en"}, 32'(ram_en_o), 0);
    sync();
  endtask

  initial begin
    logic [3:0] lg [0:7];
    lg = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
    repeat (3) @(negedge clk_i);
    sync();
    rstn_i = 1'b1;
    sync();
    load_lit("lb", 4'b0000, 32'h2, 5'd1, 32'hFFFFFFFF);
    load_lit("lbu", 4'b0100, 32'h3, 5'd2, 32'h00000080);
    load_lit("lh", 4'b0001, 32'h2, 5'd3, 32'hFFFF80FF);
    load_lit("lw", 4'b0010, 32'h0, 5'd4, 32'h80FF7F01);
    load_lit("lw_r0", 4'b0010, 32'h4, 5'd0, 32'h0);
    op(4'b1000, 32'h103, 32'hAABBCCDD, 5'd0, t1);
    @(negedge clk_i);
    chk("sb_addr", ram_addr_o, 32'h100);
    chk("sb_we", 32'(ram_we_o), 32'b1000);
    chk("sb_wdata", ram_wdata_o, 32'hDDDDDDDD);
    @(negedge clk_i);
    chk("sb_ready", 32'(ready_o), 1);
    sync();
    err_lit("lw_mis", 4'b0010, 32'h6, 1'b1, 1'b0);
    err_lit("sh_mis", 4'b1001, 32'h1, 1'b1, 1'b0);
    err_lit("ill_1100", 4'b1100, 32'h0, 1'b0, 1'b1);
    err_lit("ill_prio", 4'b0111, 32'h3, 1'b0, 1'b1);
    op(4'b1010, 32'h8, 32'hCAFEF00D, 5'd0, t1);
    op(4'b0010, 32'h8, 32'h0, 5'd7, t2);
    chk("b2b_gap", 32'(t2 - t1), 2);
    repeat (3) begin
      new_ctrl_i = 1'b1;
      ctrl_i = 4'($urandom);
      addr_i = $urandom % 64;
      sync();
    end
    new_ctrl_i = 1'b0;
    chk("b2b_lw_data", rf_data_o, 32'hCAFEF00D);
    sync();
    op(4'b0010, 32'h0, 32'h0, 5'd9, t1);
    sync();
    rstn_i = 1'b0;
    repeat (2) sync();
    rstn_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("rst_no_wb", 32'(rf_wb_o), 0);
    end
    sync();
    op(4'b1010, 32'h3C, init_word(15), 5'd0, t1);
    chk("st_en_before", 32'(ram_en_o), 1);
    rstn_i = 1'b0;
    #1;
    chk("st_en_async", 32'(ram_en_o), 0);
    chk("st_we_async", 32'(ram_we_o), 0);
    sync();
    rstn_i = 1'b1;
    sync();
    repeat (2000) begin
      new_ctrl_i = ($urandom % 3) != 0;
      ctrl_i = ($urandom % 8 == 0) ? 4'($urandom) : lg[$urandom % 8];
      addr_i = $urandom % 64;
      wdata_i = $urandom;
      regdest_i = 5'($urandom % 8);
      sync();
    end
    new_ctrl_i = 1'b0;
    repeat (8) sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
